// File: rtl/sat_alu_seq.sv
// sat_alu_seq: multi-cycle saturating add/sub/packed-nibble-add unit.
// One NIB-bit nibble is summed per clock (LSB nibble first) through a
// carry-lookahead nibble adder; the nibble carry is registered and chained
// into the next nibble.  ADD/SUB saturate the full word on overflow of the
// top nibble; PADDSB saturates each nibble independently.
// Optional feature macro: SAT_ALU_SEQ_FLAGS_EN (registered Z/V/N flags).
// WIDTH must be a multiple of NIB.
module sat_alu_seq #(
  parameter int WIDTH = 16,
  parameter int NIB   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             flag_z,
  output logic             flag_v,
  output logic             flag_n
);

  localparam int NNIB = WIDTH / NIB;
  localparam int CW   = (NNIB > 1) ? $clog2(NNIB) : 1;

  localparam logic [CW-1:0]    LAST_CNT = CW'(NNIB - 1);
  localparam logic [CW-1:0]    CNT_ONE  = CW'(1);
  localparam logic [CW-1:0]    CNT_ZERO = {CW{1'b0}};
  localparam logic [1:0]       OP_SUB    = 2'b01;
  localparam logic [1:0]       OP_PADDSB = 2'b10;
  localparam logic [WIDTH-1:0] SAT_MAX  = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SAT_MIN  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [NIB-1:0]   NIB_MAX  = {1'b0, {(NIB-1){1'b1}}};
  localparam logic [NIB-1:0]   NIB_MIN  = {1'b1, {(NIB-1){1'b0}}};

  typedef logic [NNIB-1:0][NIB-1:0] nib_vec_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Carry-lookahead nibble adder: returns {ovfl, cout, sum}.
  // Overflow is the XOR of the carry into and out of the sign bit.
  function automatic logic [NIB+1:0] cla_nib(
    input logic [NIB-1:0] x,
    input logic [NIB-1:0] y,
    input logic           cin
  );
    logic [NIB-1:0] g;
    logic [NIB-1:0] p;
    logic [NIB:0]   c;
    g    = x & y;
    p    = x ^ y;
    c[0] = cin;
    for (int i = 0; i < NIB; i++) begin
      c[i+1] = g[i] | (p[i] & c[i]);
    end
    return {c[NIB] ^ c[NIB-1], c[NIB], p ^ c[NIB-1:0]};
  endfunction

  // Registered state
  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [1:0]       r_op;
  logic             r_carry;
  logic             r_sat;
  logic [WIDTH-1:0] r_result;
  logic             r_out_valid;
  logic             r_in_ready;

  // Combinational datapath
  nib_vec_t         w_a_vec;
  nib_vec_t         w_b_vec;
  nib_vec_t         w_res_vec;
  logic             w_is_sub;
  logic             w_is_paddsb;
  logic             w_first;
  logic             w_last;
  logic [NIB-1:0]   w_a_nib;
  logic [NIB-1:0]   w_b_nib;
  logic             w_cin;
  logic [NIB+1:0]   w_add;
  logic [NIB-1:0]   w_sum;
  logic             w_cout;
  logic             w_ovfl;
  logic [NIB-1:0]   w_nib_final;
  logic [WIDTH-1:0] w_result_next;
  logic             w_sat_next;

  assign w_a_vec = r_a;
  assign w_b_vec = r_b;

  // Select the current nibble, form the adder inputs and the next result word.
  always_comb begin
    w_is_sub      = 1'b0;
    w_is_paddsb   = 1'b0;
    w_first       = 1'b0;
    w_last        = 1'b0;
    w_a_nib       = {NIB{1'b0}};
    w_b_nib       = {NIB{1'b0}};
    w_cin         = 1'b0;
    w_add         = {(NIB+2){1'b0}};
    w_sum         = {NIB{1'b0}};
    w_cout        = 1'b0;
    w_ovfl        = 1'b0;
    w_nib_final   = {NIB{1'b0}};
    w_res_vec     = r_result;
    w_result_next = r_result;
    w_sat_next    = r_sat;

    w_is_sub    = (r_op == OP_SUB);
    w_is_paddsb = (r_op == OP_PADDSB);
    w_first     = (r_cnt == CNT_ZERO);
    w_last      = (r_cnt == LAST_CNT);
    w_a_nib     = w_a_vec[r_cnt];

    // SUB is A + ~B + 1: invert B here, the +1 enters as cin of nibble 0.
    if (w_is_sub) begin
      w_b_nib = ~w_b_vec[r_cnt];
    end else begin
      w_b_nib = w_b_vec[r_cnt];
    end

    // Packed nibbles are independent lanes, so no carry ever chains.
    if (w_is_paddsb) begin
      w_cin = 1'b0;
    end else if (w_first) begin
      w_cin = w_is_sub;
    end else begin
      w_cin = r_carry;
    end

    w_add  = cla_nib(w_a_nib, w_b_nib, w_cin);
    w_sum  = w_add[NIB-1:0];
    w_cout = w_add[NIB];
    w_ovfl = w_add[NIB+1];

    // Per-lane clamp for PADDSB toward the sign of the A nibble.
    if (w_is_paddsb && w_ovfl) begin
      if (w_a_nib[NIB-1]) begin
        w_nib_final = NIB_MIN;
      end else begin
        w_nib_final = NIB_MAX;
      end
    end else begin
      w_nib_final = w_sum;
    end

    w_res_vec[r_cnt] = w_nib_final;
    w_result_next    = w_res_vec;

    // ADD/SUB: only the top nibble's overflow matters; it clamps the whole word.
    if (!w_is_paddsb && w_last && w_ovfl) begin
      if (r_a[WIDTH-1]) begin
        w_result_next = SAT_MIN;
      end else begin
        w_result_next = SAT_MAX;
      end
      w_sat_next = 1'b1;
    end else if (w_is_paddsb && w_ovfl) begin
      w_sat_next = 1'b1;
    end else begin
      w_sat_next = r_sat;
    end
  end

  // Control FSM: accept, nibble-serial compute, hold result until consumed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= CNT_ZERO;
      r_a         <= {WIDTH{1'b0}};
      r_b         <= {WIDTH{1'b0}};
      r_op        <= 2'b00;
      r_carry     <= 1'b0;
      r_sat       <= 1'b0;
      r_result    <= {WIDTH{1'b0}};
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid && r_in_ready) begin
            r_a        <= a;
            r_b        <= b;
            r_op       <= op;
            r_cnt      <= CNT_ZERO;
            r_carry    <= 1'b0;
            r_sat      <= 1'b0;
            r_in_ready <= 1'b0;
            r_state    <= S_CALC;
          end else begin
            r_in_ready <= 1'b1;
          end
        end
        S_CALC: begin
          r_result <= w_result_next;
          r_carry  <= w_cout;
          r_sat    <= w_sat_next;
          if (w_last) begin
            r_cnt       <= CNT_ZERO;
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end else begin
            r_out_valid <= 1'b1;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

`ifdef SAT_ALU_SEQ_FLAGS_EN
  logic r_flag_z;
  logic r_flag_v;
  logic r_flag_n;

  // Capture Z/V/N from the final word on the edge that enters DONE; hold otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_flag_z <= 1'b0;
      r_flag_v <= 1'b0;
      r_flag_n <= 1'b0;
    end else if ((r_state == S_CALC) && w_last) begin
      r_flag_z <= (w_result_next == {WIDTH{1'b0}});
      r_flag_v <= w_sat_next;
      r_flag_n <= w_result_next[WIDTH-1];
    end else begin
      r_flag_z <= r_flag_z;
      r_flag_v <= r_flag_v;
      r_flag_n <= r_flag_n;
    end
  end

  assign flag_z = r_flag_z;
  assign flag_v = r_flag_v;
  assign flag_n = r_flag_n;
`else
  assign flag_z = 1'b0;
  assign flag_v = 1'b0;
  assign flag_n = 1'b0;
`endif

  // in_ready is forced low while reset is held, so nothing is offered mid-reset.
  assign in_ready  = r_in_ready & ~rst;
  assign out_valid = r_out_valid;
  assign result    = r_result;

endmodule

// File: tb/tb_sat_alu_seq.sv
// Directed self-checking bench for sat_alu_seq.
module tb_sat_alu_seq;

`ifdef SAT_ALU_SEQ_FLAGS_EN
  localparam bit FLAGS_ON = 1'b1;
`else
  localparam bit FLAGS_ON = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic [1:0]  op;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
  logic        flag_z;
  logic        flag_v;
  logic        flag_n;

  int total;
  int bad;

  sat_alu_seq #(.WIDTH(16), .NIB(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flag_z    (flag_z),
    .flag_v    (flag_v),
    .flag_n    (flag_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Offer one operation, then scramble the inputs, and count edges to out_valid.
  task automatic issue_op(input logic [15:0] ta, input logic [15:0] tb_v,
                          input logic [1:0] top, output int lat);
    int w;
    w = 0;
    while (in_ready !== 1'b1 && w < 20) begin
      @(posedge clk); #1;
      w++;
    end
    a = ta; b = tb_v; op = top; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; a = 16'hDEAD; b = 16'hBEEF; op = 2'b01;
    lat = 99;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    total++; if (result !== 16'h0000) begin bad++; $display("FAIL reset_result got=%h want=0000", result); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready_held got=%b want=0", in_ready); end
    total++; if ({flag_z, flag_v, flag_n} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b want=000", {flag_z, flag_v, flag_n}); end
    rst = 1'b0;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready_rel got=%b want=1", in_ready); end
    @(posedge clk); #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_idle_valid got=%b want=0", out_valid); end
  endtask

  task automatic test_add();
    logic [15:0] va [5];
    logic [15:0] vb [5];
    logic [1:0]  vo [5];
    logic [15:0] ve [5];
    logic        vv [5];
    int lat;
    va = '{16'h1234, 16'h7000, 16'h00FF, 16'h8000, 16'h7FFF};
    vb = '{16'h1111, 16'h1000, 16'h0001, 16'h8000, 16'h0001};
    vo = '{2'b00,    2'b00,    2'b00,    2'b11,    2'b11};
    ve = '{16'h2345, 16'h7FFF, 16'h0100, 16'h8000, 16'h7FFF};
    vv = '{1'b0,     1'b1,     1'b0,     1'b1,     1'b1};
    for (int i = 0; i < 5; i++) begin
      issue_op(va[i], vb[i], vo[i], lat);
      total++; if (lat !== 4) begin bad++; $display("FAIL add[%0d]_latency got=%0d want=4", i, lat); end
      total++; if (result !== ve[i]) begin bad++; $display("FAIL add[%0d]_result got=%h want=%h", i, result, ve[i]); end
      total++; if (flag_v !== (FLAGS_ON & vv[i])) begin bad++; $display("FAIL add[%0d]_flag_v got=%b want=%b", i, flag_v, FLAGS_ON & vv[i]); end
      total++; if (flag_n !== (FLAGS_ON & ve[i][15])) begin bad++; $display("FAIL add[%0d]_flag_n got=%b want=%b", i, flag_n, FLAGS_ON & ve[i][15]); end
      total++; if (flag_z !== (FLAGS_ON & (ve[i] == 16'h0000))) begin bad++; $display("FAIL add[%0d]_flag_z got=%b", i, flag_z); end
      consume();
    end
  endtask

  task automatic test_sub();
    logic [15:0] va [3];
    logic [15:0] vb [3];
    logic [15:0] ve [3];
    logic        vv [3];
    int lat;
    va = '{16'h8000, 16'h0005, 16'h1000};
    vb = '{16'h0001, 16'h0005, 16'h0001};
    ve = '{16'h8000, 16'h0000, 16'h0FFF};
    vv = '{1'b1,     1'b0,     1'b0};
    for (int i = 0; i < 3; i++) begin
      issue_op(va[i], vb[i], 2'b01, lat);
      total++; if (lat !== 4) begin bad++; $display("FAIL sub[%0d]_latency got=%0d want=4", i, lat); end
      total++; if (result !== ve[i]) begin bad++; $display("FAIL sub[%0d]_result got=%h want=%h", i, result, ve[i]); end
      total++; if (flag_v !== (FLAGS_ON & vv[i])) begin bad++; $display("FAIL sub[%0d]_flag_v got=%b want=%b", i, flag_v, FLAGS_ON & vv[i]); end
      total++; if (flag_n !== (FLAGS_ON & ve[i][15])) begin bad++; $display("FAIL sub[%0d]_flag_n got=%b want=%b", i, flag_n, FLAGS_ON & ve[i][15]); end
      total++; if (flag_z !== (FLAGS_ON & (ve[i] == 16'h0000))) begin bad++; $display("FAIL sub[%0d]_flag_z got=%b", i, flag_z); end
      consume();
    end
  endtask

  task automatic test_paddsb();
    logic [15:0] va [3];
    logic [15:0] vb [3];
    logic [15:0] ve [3];
    logic        vv [3];
    int lat;
    va = '{16'h7171, 16'h8888, 16'h000F};
    vb = '{16'h1F1F, 16'h8888, 16'h0001};
    ve = '{16'h7070, 16'h8888, 16'h0000};
    vv = '{1'b1,     1'b1,     1'b0};
    for (int i = 0; i < 3; i++) begin
      issue_op(va[i], vb[i], 2'b10, lat);
      total++; if (lat !== 4) begin bad++; $display("FAIL paddsb[%0d]_latency got=%0d want=4", i, lat); end
      total++; if (result !== ve[i]) begin bad++; $display("FAIL paddsb[%0d]_result got=%h want=%h", i, result, ve[i]); end
      total++; if (flag_v !== (FLAGS_ON & vv[i])) begin bad++; $display("FAIL paddsb[%0d]_flag_v got=%b want=%b", i, flag_v, FLAGS_ON & vv[i]); end
      total++; if (flag_n !== (FLAGS_ON & ve[i][15])) begin bad++; $display("FAIL paddsb[%0d]_flag_n got=%b want=%b", i, flag_n, FLAGS_ON & ve[i][15]); end
      total++; if (flag_z !== (FLAGS_ON & (ve[i] == 16'h0000))) begin bad++; $display("FAIL paddsb[%0d]_flag_z got=%b", i, flag_z); end
      consume();
    end
  endtask

  task automatic test_back_pressure();
    int lat;
    issue_op(16'h8888, 16'h8888, 2'b10, lat);
    total++; if (lat !== 4) begin bad++; $display("FAIL bp_latency got=%0d want=4", lat); end
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_hold_valid[%0d] got=%b want=1", k, out_valid); end
      total++; if (result !== 16'h8888) begin bad++; $display("FAIL bp_hold_result[%0d] got=%h want=8888", k, result); end
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_hold_in_ready[%0d] got=%b want=0", k, in_ready); end
    end
    consume();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_release_valid got=%b want=0", out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_release_in_ready got=%b want=1", in_ready); end
    total++; if (flag_v !== FLAGS_ON) begin bad++; $display("FAIL bp_idle_flag_v got=%b want=%b", flag_v, FLAGS_ON); end
  endtask

  task automatic test_reset_mid_calc();
    int lat;
    a = 16'h1234; b = 16'h1111; op = 2'b00; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rstmid_valid got=%b want=0", out_valid); end
    total++; if (result !== 16'h0000) begin bad++; $display("FAIL rstmid_result got=%h want=0000", result); end
    total++; if (flag_v !== 1'b0) begin bad++; $display("FAIL rstmid_flag_v got=%b want=0", flag_v); end
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rstmid_in_ready got=%b want=1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rstmid_valid_rel got=%b want=0", out_valid); end
    issue_op(16'h0001, 16'h0001, 2'b00, lat);
    total++; if (lat !== 4) begin bad++; $display("FAIL rstmid_next_latency got=%0d want=4", lat); end
    total++; if (result !== 16'h0002) begin bad++; $display("FAIL rstmid_next_result got=%h want=0002", result); end
    consume();
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = 16'h0000;
    b         = 16'h0000;
    op        = 2'b00;
    test_reset();
    test_add();
    test_sub();
    test_paddsb();
    test_back_pressure();
    test_reset_mid_calc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
